wb_writeback_stage: RTL

- MEM/WB pipeline register and writeback driver for the 32x32 register file.
- Captures MEM-stage results, formats load data, and selects the writeback value.
- Drives the register file write port (WRITE, INADDRESS, IN, InstHIT).
- Supplies decode with bypass values for writes not yet visible at the register file's asynchronous read ports, and counts retired instructions.

---
 rtl/wb_writeback_stage_if.sv | 46 ++++
 rtl/wb_writeback_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_writeback_stage_if.sv
// MEM/WB stage bus: MEM-stage results and pipeline control in, register
// file write port, decode bypass and retire count out.
interface wb_writeback_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic              MEM_VALID;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] MEM_RD;
  logic [1:0]        MEM_WBSEL;
  logic [2:0]        MEM_FUNCT3;
  logic [1:0]        MEM_ADDR_LO;
  logic [DATA_W-1:0] MEM_ALU;
  logic [DATA_W-1:0] MEM_LOAD;
  logic [DATA_W-1:0] MEM_PC4;
  logic              STALL;
  logic              FLUSH;
  logic [ADDR_W-1:0] RS1ADDR;
  logic [ADDR_W-1:0] RS2ADDR;
  logic              WRITE;
  logic [ADDR_W-1:0] INADDRESS;
  logic [DATA_W-1:0] IN;
  logic              InstHIT;
  logic              FWD1_EN;
  logic              FWD2_EN;
  logic [DATA_W-1:0] FWD1;
  logic [DATA_W-1:0] FWD2;
  logic [CNT_W-1:0]  RETIRE_CNT;

  // Pipeline side: drives MEM results and control, observes writeback.
  modport master (
    output MEM_VALID, MEM_WRITE, MEM_RD, MEM_WBSEL, MEM_FUNCT3, MEM_ADDR_LO,
           MEM_ALU, MEM_LOAD, MEM_PC4, STALL, FLUSH, RS1ADDR, RS2ADDR,
    input  WRITE, INADDRESS, IN, InstHIT, FWD1_EN, FWD2_EN, FWD1, FWD2,
           RETIRE_CNT
  );

  // Writeback stage side.
  modport slave (
    input  MEM_VALID, MEM_WRITE, MEM_RD, MEM_WBSEL, MEM_FUNCT3, MEM_ADDR_LO,
           MEM_ALU, MEM_LOAD, MEM_PC4, STALL, FLUSH, RS1ADDR, RS2ADDR,
    output WRITE, INADDRESS, IN, InstHIT, FWD1_EN, FWD2_EN, FWD1, FWD2,
           RETIRE_CNT
  );
endinterface

// File: rtl/wb_writeback_stage.sv
// MEM/WB pipeline register and register file writeback driver.
// Formats load data at capture, presents each instruction exactly once to the
// register file, bypasses writes not yet visible at the asynchronous read
// ports, and counts retired instructions.
module wb_writeback_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input logic                 CLK,
  input logic                 RESET,
  wb_writeback_stage_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PRESENT = 2'd1,
    ST_HELD    = 2'd2
  } stage_state_e;

  stage_state_e      state_r;
  stage_state_e      state_nxt_s;
  logic              capture_s;

  logic              wb_write_r;
  logic [ADDR_W-1:0] wb_rd_r;
  logic [DATA_W-1:0] wb_data_r;
  logic [DATA_W-1:0] wb_value_s;

  logic              last_v_r;
  logic [ADDR_W-1:0] last_rd_r;
  logic [DATA_W-1:0] last_data_r;

  logic [CNT_W-1:0]  retire_cnt_r;

  logic              inst_hit_s;
  logic              write_s;
  logic              fwd1_en_s;
  logic              fwd2_en_s;
  logic [DATA_W-1:0] fwd1_s;
  logic [DATA_W-1:0] fwd2_s;

  // Load data formatting; the byte/half lane layout assumes a 32-bit word.
  function automatic logic [31:0] format_load(
    input logic [2:0]  funct3,
    input logic [1:0]  addr_lo,
    input logic [31:0] word
  );
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (addr_lo)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    // Halfword lane comes from bit 1 only; a misaligned bit 0 is ignored.
    if (addr_lo[1]) begin
      half_v = word[31:16];
    end else begin
      half_v = word[15:0];
    end
    case (funct3)
      3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
      3'b100:  res_v = {24'd0, byte_v};
      3'b001:  res_v = {{16{half_v[15]}}, half_v};
      3'b101:  res_v = {16'd0, half_v};
      default: res_v = word;
    endcase
    return res_v;
  endfunction

  // Select the writeback value from the MEM-stage sources.
  always_comb begin
    wb_value_s = bus.MEM_ALU;
    case (bus.MEM_WBSEL)
      2'b01:   wb_value_s = format_load(bus.MEM_FUNCT3, bus.MEM_ADDR_LO, bus.MEM_LOAD);
      2'b10:   wb_value_s = bus.MEM_PC4;
      default: wb_value_s = bus.MEM_ALU;
    endcase
  end

  // Stage next-state and capture decision; FLUSH overrides STALL.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    if (bus.FLUSH) begin
      state_nxt_s = ST_EMPTY;
    end else if (bus.STALL) begin
      case (state_r)
        ST_PRESENT: state_nxt_s = ST_HELD;
        ST_HELD:    state_nxt_s = ST_HELD;
        default:    state_nxt_s = ST_EMPTY;
      endcase
    end else begin
      capture_s = 1'b1;
      if (bus.MEM_VALID) begin
        state_nxt_s = ST_PRESENT;
      end else begin
        state_nxt_s = ST_EMPTY;
      end
    end
  end

  // Stage state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Stage payload; loaded on every capture so INADDRESS/IN track the stage even when empty.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wb_write_r <= 1'b0;
      wb_rd_r    <= {ADDR_W{1'b0}};
      wb_data_r  <= {DATA_W{1'b0}};
    end else if (capture_s) begin
      wb_write_r <= bus.MEM_WRITE;
      wb_rd_r    <= bus.MEM_RD;
      wb_data_r  <= wb_value_s;
    end
  end

  // Register file port: presented only in PRESENT, so a stall never repeats the write.
  always_comb begin
    inst_hit_s = (state_r == ST_PRESENT);
    write_s    = inst_hit_s & wb_write_r & (wb_rd_r != {ADDR_W{1'b0}});
  end

  // Remember the last committed write to cover register file write-to-read latency.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_v_r    <= 1'b0;
      last_rd_r   <= {ADDR_W{1'b0}};
      last_data_r <= {DATA_W{1'b0}};
    end else if (write_s) begin
      last_v_r    <= 1'b1;
      last_rd_r   <= wb_rd_r;
      last_data_r <= wb_data_r;
    end
  end

  // Retired instruction counter, wraps naturally.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      retire_cnt_r <= {CNT_W{1'b0}};
    end else if (inst_hit_s) begin
      retire_cnt_r <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Bypass for RS1: in-flight write first, then the last committed write; x0 never forwards.
  always_comb begin
    fwd1_en_s = 1'b0;
    fwd1_s    = {DATA_W{1'b0}};
    if (bus.RS1ADDR == {ADDR_W{1'b0}}) begin
      fwd1_en_s = 1'b0;
    end else if (write_s && (wb_rd_r == bus.RS1ADDR)) begin
      fwd1_en_s = 1'b1;
      fwd1_s    = wb_data_r;
    end else if (last_v_r && (last_rd_r == bus.RS1ADDR)) begin
      fwd1_en_s = 1'b1;
      fwd1_s    = last_data_r;
    end else begin
      fwd1_en_s = 1'b0;
    end
  end

  // Bypass for RS2, same priority as RS1.
  always_comb begin
    fwd2_en_s = 1'b0;
    fwd2_s    = {DATA_W{1'b0}};
    if (bus.RS2ADDR == {ADDR_W{1'b0}}) begin
      fwd2_en_s = 1'b0;
    end else if (write_s && (wb_rd_r == bus.RS2ADDR)) begin
      fwd2_en_s = 1'b1;
      fwd2_s    = wb_data_r;
    end else if (last_v_r && (last_rd_r == bus.RS2ADDR)) begin
      fwd2_en_s = 1'b1;
      fwd2_s    = last_data_r;
    end else begin
      fwd2_en_s = 1'b0;
    end
  end

  assign bus.WRITE      = write_s;
  assign bus.INADDRESS  = wb_rd_r;
  assign bus.IN         = wb_data_r;
  assign bus.InstHIT    = inst_hit_s;
  assign bus.FWD1_EN    = fwd1_en_s;
  assign bus.FWD2_EN    = fwd2_en_s;
  assign bus.FWD1       = fwd1_s;
  assign bus.FWD2       = fwd2_s;
  assign bus.RETIRE_CNT = retire_cnt_r;

endmodule
